// File: rtl/mc_ctrl_pkg.sv
// Shared state encoding, opcodes and control-field encodings for the multi-cycle control unit.
// MC_CONTROL_JUMP_EN (see mc_control_unit) decides whether the JUMP encoding is ever reached.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// Moore output decode: state plus mem_ready to datapath control word.
// JUMP outputs exist only when MC_CONTROL_JUMP_EN is defined.
module mc_ctrl_out_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                // Write strobe held across the whole stall; retire only on completion.
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`ifdef MC_CONTROL_JUMP_EN
            JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-style control FSM with memory stall handshake, retire counter and illegal-op flag.
// Define MC_CONTROL_JUMP_EN to decode opcode 000010 as j; otherwise it is illegal.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W  = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             illegal_op,
    output logic [3:0]       state
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               illegal_q, illegal_d;
    ctrl_t              ctrl, ctrl_out;

    mc_ctrl_out_decode u_out_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    always_comb begin
        state_d   = FETCH;
        illegal_d = illegal_q;
        retired_d = retired_q + CNT_W'(ctrl.instr_done);
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
`ifdef MC_CONTROL_JUMP_EN
                    OP_J:         state_d = JUMP;
`endif
                    default: begin
                        // PC already advanced in FETCH, so just drop the instruction.
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
            EXEC:   state_d = RWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign ctrl_out = rst_n ? ctrl : '0;

    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign i_or_d        = ctrl_out.i_or_d;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign ir_write      = ctrl_out.ir_write;
    assign reg_dst       = ctrl_out.reg_dst;
    assign reg_write     = ctrl_out.reg_write;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign pc_source     = ctrl_out.pc_source;
    assign instr_done    = ctrl_out.instr_done;
    assign retired       = retired_q;
    assign illegal_op    = illegal_q;
    assign state         = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed scoreboard bench for mc_control_unit; the JUMP path is expected only with MC_CONTROL_JUMP_EN.
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  op = 6'b0;
    logic        mem_ready = 1'b1;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
    logic        ir_write, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [15:0] retired;
    logic [3:0]  state;

    mc_control_unit #(.OP_W(6), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .retired(retired),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [5:0] opc;
        logic       ill;
    } step_t;

    step_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    exp_retired = 0;
    logic  exp_ill = 1'b0;

    localparam logic [3:0] S_FE = 4'd0, S_DE = 4'd1, S_MA = 4'd2, S_MR = 4'd3,
                           S_MB = 4'd4, S_MW = 4'd5, S_EX = 4'd6, S_RW = 4'd7,
                           S_BR = 4'd8, S_AE = 4'd9, S_AW = 4'd10, S_JP = 4'd11;

    // Reference control word, ordered {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
    // mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done}.
    function automatic logic [16:0] ref_ctrl(input logic [3:0] st, input logic mr);
        logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0, rd = 0, rw = 0, asa = 0, dn = 0;
        logic [1:0] asb = 0, aop = 0, psrc = 0;
        case (st)
            S_FE: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            S_DE: asb = 2'b11;
            S_MA: begin asa = 1; asb = 2'b10; end
            S_MR: begin mrd = 1; iod = 1; end
            S_MB: begin rw = 1; m2r = 1; dn = 1; end
            S_MW: begin mwr = 1; iod = 1; dn = mr; end
            S_EX: begin asa = 1; aop = 2'b10; end
            S_RW: begin rw = 1; rd = 1; dn = 1; end
            S_BR: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; dn = 1; end
            S_AE: begin asa = 1; asb = 2'b10; end
            S_AW: begin rw = 1; dn = 1; end
`ifdef MC_CONTROL_JUMP_EN
            S_JP: begin pw = 1; psrc = 2'b10; dn = 1; end
`endif
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, m2r, irw, rd, rw, asa, asb, aop, psrc, dn};
    endfunction

    function automatic logic [16:0] obs_ctrl();
        return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] opc, input logic ill);
        step_t s;
        s.st = st; s.mr = mr; s.opc = opc; s.ill = ill;
        sb.push_back(s);
    endtask

    // Called at a negedge: drive each step, check mid-cycle, then clock it.
    task automatic drain(input string name);
        step_t s;
        logic [16:0] expc;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            op = s.opc;
            mem_ready = s.mr;
            #1;
            expc = ref_ctrl(s.st, s.mr);
            chk({name, ".state"}, 32'(state), 32'(s.st));
            chk({name, ".ctrl"}, 32'(obs_ctrl()), 32'(expc));
            chk({name, ".retired"}, 32'(retired), 32'(exp_retired));
            chk({name, ".illegal"}, 32'(illegal_op), 32'(s.ill));
            $display("step %s state=%0d mr=%0b op=%06b ctrl=%05h retired=%0d", name, state, s.mr, s.opc, obs_ctrl(), retired);
            if (expc[0]) exp_retired = (exp_retired + 1) % 65536;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset phase: outputs forced low even though state decodes to FETCH.
        #2 rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst.state", 32'(state), 32'(S_FE));
            chk("rst.ctrl", 32'(obs_ctrl()), 32'd0);
            chk("rst.retired", 32'(retired), 32'd0);
            chk("rst.illegal", 32'(illegal_op), 32'd0);
            $display("step reset state=%0d ctrl=%05h", state, obs_ctrl());
        end
        @(negedge clk);
        rst_n = 1'b1;

        // lw, no stall: 5 cycles
        push(S_FE, 1, 6'b100011, 0); push(S_DE, 1, 6'b100011, 0); push(S_MA, 1, 6'b100011, 0);
        push(S_MR, 1, 6'b100011, 0); push(S_MB, 1, 6'b100011, 0);
        drain("lw");
        chk("lw.retired_after", 32'(retired), 32'd1);

        // sw: one FETCH stall, three MEMWR stall cycles
        push(S_FE, 0, 6'b101011, 0); push(S_FE, 1, 6'b101011, 0); push(S_DE, 1, 6'b101011, 0);
        push(S_MA, 1, 6'b101011, 0);
        push(S_MW, 0, 6'b101011, 0); push(S_MW, 0, 6'b101011, 0); push(S_MW, 0, 6'b101011, 0);
        push(S_MW, 1, 6'b101011, 0);
        drain("sw");
        chk("sw.retired_after", 32'(retired), 32'd2);

        // R-type, beq, addi, then lw with two MEMRD stalls
        push(S_FE, 1, 6'b000000, 0); push(S_DE, 1, 6'b000000, 0); push(S_EX, 1, 6'b000000, 0);
        push(S_RW, 1, 6'b000000, 0);
        push(S_FE, 1, 6'b000100, 0); push(S_DE, 1, 6'b000100, 0); push(S_BR, 1, 6'b000100, 0);
        push(S_FE, 1, 6'b001000, 0); push(S_DE, 1, 6'b001000, 0); push(S_AE, 1, 6'b001000, 0);
        push(S_AW, 1, 6'b001000, 0);
        push(S_FE, 1, 6'b100011, 0); push(S_DE, 1, 6'b100011, 0); push(S_MA, 1, 6'b100011, 0);
        push(S_MR, 0, 6'b100011, 0); push(S_MR, 0, 6'b100011, 0); push(S_MR, 1, 6'b100011, 0);
        push(S_MB, 1, 6'b100011, 0);
        drain("rba");
        chk("rba.retired_after", 32'(retired), 32'd6);

`ifdef MC_CONTROL_JUMP_EN
        push(S_FE, 1, 6'b000010, 0); push(S_DE, 1, 6'b000010, 0); push(S_JP, 1, 6'b000010, 0);
        exp_ill = 1'b0;
`else
        push(S_FE, 1, 6'b000010, 0); push(S_DE, 1, 6'b000010, 0);
        exp_ill = 1'b1;
`endif
        drain("j");

        // Unsupported opcode: drops back to FETCH, flag sticks through a following R-type
        push(S_FE, 1, 6'b111111, exp_ill); push(S_DE, 1, 6'b111111, exp_ill);
        push(S_FE, 1, 6'b000000, 1); push(S_DE, 1, 6'b000000, 1); push(S_EX, 1, 6'b000000, 1);
        push(S_RW, 1, 6'b000000, 1);
        drain("ill");
`ifdef MC_CONTROL_JUMP_EN
        chk("ill.retired_after", 32'(retired), 32'd8);
`else
        chk("ill.retired_after", 32'(retired), 32'd7);
`endif

        // Asynchronous reset in the middle of a sw stall
        push(S_FE, 1, 6'b101011, 1); push(S_DE, 1, 6'b101011, 1); push(S_MA, 1, 6'b101011, 1);
        push(S_MW, 0, 6'b101011, 1);
        drain("swabort");
        mem_ready = 1'b0;
        #1;
        chk("abort.pre_state", 32'(state), 32'(S_MW));
        chk("abort.pre_mem_write", 32'(mem_write), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.state", 32'(state), 32'(S_FE));
        chk("abort.ctrl", 32'(obs_ctrl()), 32'd0);
        chk("abort.retired", 32'(retired), 32'd0);
        chk("abort.illegal", 32'(illegal_op), 32'd0);
        $display("step abort state=%0d ctrl=%05h retired=%0d", state, obs_ctrl(), retired);
        @(negedge clk);
        rst_n = 1'b1;
        exp_retired = 0;
        push(S_FE, 1, 6'b001000, 0); push(S_DE, 1, 6'b001000, 0); push(S_AE, 1, 6'b001000, 0);
        push(S_AW, 1, 6'b001000, 0); push(S_FE, 1, 6'b001000, 0);
        drain("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
